// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and default baud divider.
// Used by both the transmit and receive paths.
package uart_pkg;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int UART_DATA_W          = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_e;

endpackage

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..CLKS_PER_BIT-1 while enabled, tick_o marks the last cycle.
// Held at zero by clr_i so the first period after a clear is always full length.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic reset,
    input  logic clr_i,
    input  logic en_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign tick_o = en_i && (cnt_q == LAST);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || tick_o) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with valid/ready byte input; all outputs registered.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1/8E2 frames).
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int STOP_BITS    = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [UART_DATA_W-1:0] in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic                   tx,
    output logic                   busy,
    output logic                   done
);

    localparam int IDX_W = $clog2(UART_DATA_W);
    localparam logic [IDX_W-1:0] LAST_BIT  = IDX_W'(UART_DATA_W - 1);
    localparam logic             LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_e            state_q;
    logic [UART_DATA_W-1:0] shift_q;
    logic [IDX_W-1:0]       bit_idx_q;
    logic                   stop_idx_q;
    logic                   tx_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   tick;

    // The counter only runs inside a frame, so each accept starts a clean period.
    uart_baud_cnt #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .reset (reset),
        .clr_i (!busy_q),
        .en_i  (busy_q),
        .tick_o(tick)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bit_idx_q  <= '0;
            stop_idx_q <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid && ready_q) begin
                        shift_q    <= in_data;
                        bit_idx_q  <= '0;
                        stop_idx_q <= 1'b0;
                        state_q    <= START;
                        tx_q       <= 1'b0;
                        ready_q    <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (tick) begin
                        state_q   <= DATA;
                        bit_idx_q <= '0;
                        tx_q      <= shift_q[0];
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                            state_q <= PARITY;
                            tx_q    <= ^shift_q;
`else
                            state_q <= STOP;
                            tx_q    <= 1'b1;
`endif
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                            tx_q      <= shift_q[bit_idx_q + 1'b1];
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        state_q <= STOP;
                        tx_q    <= 1'b1;
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (stop_idx_q == LAST_STOP) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            stop_idx_q <= stop_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign tx       = tx_q;
    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign done     = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Randomised bench for uart_tx with a bit-level frame model and a mid-bit sampling receiver.
module tb_uart_tx;

    localparam int CPB = 4;
    localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif
    localparam int NBITS = 1 + 8 + PB + SB;
    localparam int FLEN  = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic       tx;
    logic       busy;
    logic       done;

    int checks   = 0;
    int failures = 0;
    logic wave [64];

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .STOP_BITS   (SB)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .in_data (in_data),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .tx      (tx),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference frame: bit b of the frame for byte d.
    function automatic logic exp_bit(input logic [7:0] d, input int b);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
        if (PB != 0 && b == 9) return ^d;
        return 1'b1;
    endfunction

    task automatic idle_check(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, "_tx"}, 32'(tx), 32'd1);
            check({tag, "_rdy"}, 32'(in_ready), 32'd1);
            check({tag, "_busy"}, 32'(busy), 32'd0);
            check({tag, "_done"}, 32'(done), 32'd0);
        end
    endtask

    // Offers d and returns just after the accept edge.
    task automatic send(input logic [7:0] d, input bit hold, input logic [7:0] nxt);
        bit ok;
        ok       = 1'b0;
        in_data  = d;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        if (!ok) check("accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        if (hold) begin
            in_data = nxt;
        end else begin
            in_valid = 1'b0;
            in_data  = 8'($urandom);
        end
    endtask

    // Captures one frame starting in the cycle after the accept edge; ends in the done cycle.
    task automatic capture(input logic [7:0] d, input bit poke, input string tag);
        int werr, derr, rerr;
        logic [7:0] rx;
        werr = 0;
        derr = 0;
        rerr = 0;
        for (int k = 0; k < FLEN; k++) begin
            @(negedge clk);
            wave[k] = tx;
            if (tx !== exp_bit(d, k / CPB)) werr++;
            if (done !== 1'b0) derr++;
            if (in_ready !== 1'b0 || busy !== 1'b1) rerr++;
            if (poke) begin
                if (k == 5) begin
                    in_valid = 1'b1;
                    in_data  = 8'hFF;
                end
                if (k == 9) in_data = 8'($urandom);
                if (k == 20) in_valid = 1'b0;
            end
        end
        @(negedge clk);
        check({tag, "_wave_errs"}, 32'(werr), 32'd0);
        check({tag, "_early_done"}, 32'(derr), 32'd0);
        check({tag, "_rdy_busy_errs"}, 32'(rerr), 32'd0);
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_done_rdy"}, 32'(in_ready), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_tx"}, 32'(tx), 32'd1);
        for (int i = 0; i < 8; i++) rx[i] = wave[(i + 1) * CPB + CPB / 2];
        check({tag, "_rx_byte"}, 32'(rx), 32'(d));
        check({tag, "_rx_start"}, 32'(wave[CPB / 2]), 32'd0);
        check({tag, "_rx_stop"}, 32'(wave[(9 + PB) * CPB + CPB / 2]), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] d;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = 8'h00;
        #1;
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_rdy", 32'(in_ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        idle_check(20, "idle");

        send(8'hA5, 1'b0, 8'h00);
        capture(8'hA5, 1'b0, "a5");
        idle_check(3, "a5_after");

        // Held valid: the second byte goes in on the done-cycle edge.
        send(8'h55, 1'b1, 8'h0F);
        capture(8'h55, 1'b0, "b2b0");
        check("b2b_valid_held", 32'(in_valid), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        capture(8'h0F, 1'b0, "b2b1");
        idle_check(2, "b2b_after");

        send(8'hC3, 1'b0, 8'h00);
        capture(8'hC3, 1'b1, "ignore");
        idle_check(2, "ignore_after");

        // Reset in the first cycle of data bit 3 of 0x96 (bit value 0).
        send(8'h96, 1'b0, 8'h00);
        repeat (17) @(negedge clk);
        check("pre_rst_tx", 32'(tx), 32'(exp_bit(8'h96, 4)));
        #1;
        reset = 1'b1;
        #1;
        check("midrst_tx", 32'(tx), 32'd1);
        check("midrst_rdy", 32'(in_ready), 32'd1);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle_check(12, "post_rst");
        send(8'h3C, 1'b0, 8'h00);
        capture(8'h3C, 1'b0, "x3c");
        idle_check(1, "x3c_after");

        send(8'h07, 1'b0, 8'h00);
        capture(8'h07, 1'b0, "x07");
        idle_check(1, "x07_after");

        for (int n = 0; n < 6; n++) begin
            d = 8'($urandom);
            idle_check(int'($urandom_range(0, 3)), "rnd_gap");
            send(d, 1'b0, 8'h00);
            capture(d, 1'b0, "rnd");
        end
        idle_check(2, "end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_tx.md
Name: uart_tx

Overview:
- 8N1 UART transmitter. It serialises one byte per frame onto the tx line: start bit (0), 8 data bits LSB first, then stop bit(s) (1).
- It is the transmit-side counterpart of the receive path and sits between the core's MMIO/peripheral bus and the board TX pin.
- Byte input uses a valid/ready handshake. Bit timing comes from an internal clock-cycle divider.

Parameters:
- CLKS_PER_BIT, 868, clock cycles per bit period (100 MHz / 115200). Must be >= 2.
- STOP_BITS, 1, number of stop bits. Legal values: 1 or 2.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  8  byte to transmit. Sampled only on the accept cycle.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  transmitter can accept a byte. High only in IDLE.
- tx  output  1  serial line, idles high. Driven from a register.
- busy  output  1  a frame is in progress (any state other than IDLE).
- done  output  1  one-cycle pulse when the final stop bit completes.

Behaviour:
- Reset (asynchronous, takes effect immediately):
  - state=IDLE, tx=1, in_ready=1, busy=0, done=0.
  - Baud counter, bit index and shift register all set to 0.
- Accept: on a rising edge with in_valid && in_ready.
  - in_data is latched into the shift register.
  - state goes to START and tx=0 from the next cycle.
- Bit timing: every bit (start, each data bit, parity, each stop bit) holds tx for exactly CLKS_PER_BIT cycles.
  - baud_cnt counts 0..CLKS_PER_BIT-1 and has width $clog2(CLKS_PER_BIT).
  - The state/bit advances on the cycle where baud_cnt == CLKS_PER_BIT-1, and baud_cnt wraps to 0 on that cycle.
- FSM states and transitions:
  - IDLE: tx=1. Go to START on accept.
  - START: tx=0. After one bit period go to DATA with bit_idx=0.
  - DATA: tx=shift_reg[bit_idx], LSB first. At each period end, bit_idx increments. After bit_idx==7 completes, go to PARITY if enabled, otherwise STOP.
  - PARITY: present only with the optional feature (see below).
  - STOP: tx=1 for STOP_BITS bit periods. Then return to IDLE and pulse done for exactly one cycle, coincident with the first IDLE cycle.
- Frame length: from accept edge to done pulse is exactly (10 + STOP_BITS - 1) * CLKS_PER_BIT cycles, plus CLKS_PER_BIT more when parity is enabled.
- Back-to-back frames:
  - in_ready is high in the done cycle, so a byte held valid is accepted on that edge.
  - The result is exactly one idle-high clock cycle between frames, and no bit-period gap.
- in_valid while busy: ignored. in_data changes after accept have no effect on the frame in flight.
- Reset mid-frame: tx returns to 1 immediately, the partial frame is abandoned, and done is not pulsed.
- tx, in_ready and busy are all registered. There is no combinational path from in_valid to tx.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = ^latched_byte (even parity) for one bit period.
  - The frame becomes 8E1 (or 8E2 with STOP_BITS=2).
- Undefined: no PARITY state exists in the RTL and the frame is 8N1.

Decomposition:
- Shared package uart_pkg holds:
  - The state encoding: IDLE=3'd0, START=3'd1, DATA=3'd2, PARITY=3'd3, STOP=3'd4.
  - DEFAULT_CLKS_PER_BIT=868.
  - The UART_DATA_W=8 constant.
- The receive path reuses this package.
- One natural sub-module is uart_baud_cnt. It is a parameterised bit-period counter with clear and tick outputs, reusable by the receiver. Everything else stays in uart_tx.

Test Plan:
- Use CLKS_PER_BIT=4 and STOP_BITS=1 for all scenarios.
- Reset, then 20 idle cycles. Required: tx=1, in_ready=1, busy=0, done=0 throughout.
- Send 0xA5 (1 cycle of in_valid). Required:
  - tx sequence per 4-cycle period: 0, 1,0,1,0,0,1,0,1, 1.
  - done pulses exactly 40 cycles after the accept edge.
- Hold in_valid with 0x55 then 0x0F. Required:
  - Second accept happens in the done cycle of the first frame.
  - Exactly one idle-high cycle between frames.
  - Both frames decode correctly via a bench-side receiver model.
- Assert in_valid with 0xFF mid-frame, and change in_data after accept. Required: in_ready=0, the byte is ignored, and the transmitted byte is unchanged.
- Assert reset during data bit 3. Required:
  - tx=1 in the same cycle, state=IDLE, no done pulse.
  - The next byte 0x3C is sent correctly.
- With UART_TX_PARITY_EN and 0x07. Required: parity bit = 1, and done arrives at 44 cycles.
- Repeat the 0x07 case with STOP_BITS=2 and parity enabled. Required: stop high for 8 cycles, done at 48 cycles.
